// File: rtl/nrisc_mem_pkg.sv
// Shared definitions for the DataMEM front-end: width defaults, the
// per-core request record and the saturating-increment helper that the
// conflict counter uses.
package nrisc_mem_pkg;

  localparam int TAM_DEF        = 16;
  localparam int LMEM_DEF       = 8;
  localparam int CONFLICT_CNT_W = 16;

  typedef struct packed {
    logic                write;
    logic [TAM_DEF-1:0]  addr;
    logic [TAM_DEF-1:0]  wdata;
  } memReq_t;

  function automatic logic [CONFLICT_CNT_W-1:0] satInc(
    input logic [CONFLICT_CNT_W-1:0] c);
    return (&c) ? c : c + CONFLICT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Same-address conflict detector with a round-robin tie-break between the
// two cores.
//   clk, rst   clock / async active-low reset
//   valid      per-core request present
//   write      per-core store flag
//   addr       per-core implemented address bits
//   ready      per-core grant (combinational)
//   conflict   this cycle is a conflict cycle
//   rrPtr      core that wins the next conflict
module mem_rr_arbiter
  import nrisc_mem_pkg::*;
#(
  parameter int Ncores = 2,
  parameter int Lmem   = LMEM_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [Ncores-1:0]           valid,
  input  logic [Ncores-1:0]           write,
  input  logic [Ncores-1:0][Lmem-1:0] addr,
  output logic [Ncores-1:0]           ready,
  output logic                        conflict,
  output logic                        rrPtr
);

  // Two loads to one word can both proceed; any store in the pair cannot.
  assign conflict = (&valid) && (addr[0] == addr[1]) && (|write);

  assign ready = conflict ? (Ncores'(1) << rrPtr) : '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rrPtr <= 1'b0;
    else      rrPtr <= rrPtr ^ conflict;
  end

endmodule

// File: rtl/data_mem_port_arbiter.sv
// Front-end for the dual-port DataMEM: arbitrates same-address conflicts,
// registers the memory controls, returns load data two cycles after accept
// and counts conflict cycles.
//   clk, rst                 clock / async active-low reset
//   req_valid/ready/write    per-core handshake and store flag
//   req_addr0/1, req_wdata0/1 per-core address and store data
//   rsp_valid, rsp_err       per-core one-cycle response pulses
//   rsp_data0/1              per-core load result
//   dataADDR*, dataIN*, dataWrite, dataLoad, dataOUT*  DataMEM ports
//   conflict_cnt             saturating conflict-cycle count
module data_mem_port_arbiter
  import nrisc_mem_pkg::*;
#(
  parameter int Ncores = 2,
  parameter int TAM    = TAM_DEF,
  parameter int Lmem   = LMEM_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [Ncores-1:0]         req_valid,
  output logic [Ncores-1:0]         req_ready,
  input  logic [Ncores-1:0]         req_write,
  input  logic [TAM-1:0]            req_addr0,
  input  logic [TAM-1:0]            req_addr1,
  input  logic [TAM-1:0]            req_wdata0,
  input  logic [TAM-1:0]            req_wdata1,
  output logic [Ncores-1:0]         rsp_valid,
  output logic [TAM-1:0]            rsp_data0,
  output logic [TAM-1:0]            rsp_data1,
  output logic [Ncores-1:0]         rsp_err,
  output logic [TAM-1:0]            dataADDR0,
  output logic [TAM-1:0]            dataADDR1,
  output logic [TAM-1:0]            dataIN0,
  output logic [TAM-1:0]            dataIN1,
  output logic [Ncores-1:0]         dataWrite,
  output logic [Ncores-1:0]         dataLoad,
  input  logic [TAM-1:0]            dataOUT0,
  input  logic [TAM-1:0]            dataOUT1,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

  logic [Ncores-1:0][TAM-1:0]  reqAddr, reqWdata, memOut;
  logic [Ncores-1:0][TAM-1:0]  issAddr, issData, rspData;
  logic [Ncores-1:0][Lmem-1:0] lowAddr;
  logic [Ncores-1:0]           accept, oor;
  // Per-core valid shift registers: [0] = issue stage, [1] = DataMEM read.
  logic [Ncores-1:0][1:0]      ldPipe, errPipe;
  logic                        conflict, rrPtr;

  assign reqAddr  = {req_addr1, req_addr0};
  assign reqWdata = {req_wdata1, req_wdata0};
  assign memOut   = {dataOUT1, dataOUT0};

  for (genvar n = 0; n < Ncores; n++) begin : gLane
    assign lowAddr[n] = reqAddr[n][Lmem-1:0];
    assign oor[n]     = |reqAddr[n][TAM-1:Lmem];
  end

  mem_rr_arbiter #(.Ncores(Ncores), .Lmem(Lmem)) uArb (
    .clk      (clk),
    .rst      (rst),
    .valid    (req_valid),
    .write    (req_write),
    .addr     (lowAddr),
    .ready    (req_ready),
    .conflict (conflict),
    .rrPtr    (rrPtr)
  );

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issAddr   <= '0;
      issData   <= '0;
      dataWrite <= '0;
      dataLoad  <= '0;
      ldPipe    <= '0;
      errPipe   <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rspData   <= '0;
    end else begin
      for (int n = 0; n < Ncores; n++) begin
        issAddr[n]   <= accept[n] ? reqAddr[n]  : '0;
        issData[n]   <= accept[n] ? reqWdata[n] : '0;
        // Out-of-range requests are accepted but never reach the array.
        dataWrite[n] <= accept[n] &  req_write[n] & ~oor[n];
        dataLoad[n]  <= accept[n] & ~req_write[n] & ~oor[n];
        ldPipe[n]    <= {ldPipe[n][0],  accept[n] & ~req_write[n]};
        errPipe[n]   <= {errPipe[n][0], accept[n] & oor[n]};
        rsp_valid[n] <= ldPipe[n][1];
        rsp_err[n]   <= errPipe[n][1];
        if (ldPipe[n][1])
          rspData[n] <= errPipe[n][1] ? '0 : memOut[n];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          conflict_cnt <= '0;
    else if (conflict) conflict_cnt <= satInc(conflict_cnt);
  end

  assign dataADDR0 = issAddr[0];
  assign dataADDR1 = issAddr[1];
  assign dataIN0   = issData[0];
  assign dataIN1   = issData[1];
  assign rsp_data0 = rspData[0];
  assign rsp_data1 = rspData[1];

endmodule

// File: tb/tb_data_mem_port_arbiter.sv
module tb_data_mem_port_arbiter;
  import nrisc_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, req_write = '0;
  logic [15:0] req_addr0 = '0, req_addr1 = '0, req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]  rsp_valid, rsp_err, dataWrite, dataLoad;
  logic [15:0] rsp_data0, rsp_data1, dataADDR0, dataADDR1, dataIN0, dataIN1;
  logic [15:0] dataOUT0, dataOUT1, conflict_cnt;

  data_mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rsp_err(rsp_err),
    .dataADDR0(dataADDR0), .dataADDR1(dataADDR1),
    .dataIN0(dataIN0), .dataIN1(dataIN1),
    .dataWrite(dataWrite), .dataLoad(dataLoad),
    .dataOUT0(dataOUT0), .dataOUT1(dataOUT1),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port DataMEM: synchronous write, registered read.
  logic [15:0] mem [0:255] = '{default: '0};
  always @(posedge clk) begin
    if (dataWrite[0]) mem[dataADDR0[7:0]] <= dataIN0;
    if (dataWrite[1]) mem[dataADDR1[7:0]] <= dataIN1;
    dataOUT0 <= mem[dataADDR0[7:0]];
    dataOUT1 <= mem[dataADDR1[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        vld;
    logic        err;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb0[$], sb1[$];
  logic [15:0] refMem [0:255] = '{default: '0};
  logic        rrModel = 1'b0;
  logic [15:0] cntModel = '0;
  int          nChecks = 0, nFail = 0, rspSeen = 0;

  // Response monitor: pops the scoreboard on the cycle each response is due.
  exp_t        mE;
  logic        mDue;
  logic [15:0] mData;
  always @(negedge clk) if (rst) begin
    for (int n = 0; n < 2; n++) begin
      if (rsp_valid[n]) rspSeen++;
      mData = (n == 0) ? rsp_data0 : rsp_data1;
      if (n == 0) mDue = (sb0.size() > 0) && (sb0[0].due == cyc);
      else        mDue = (sb1.size() > 0) && (sb1[0].due == cyc);
      if (mDue) begin
        if (n == 0) mE = sb0.pop_front();
        else        mE = sb1.pop_front();
        nChecks++;
        if (rsp_valid[n] !== mE.vld || rsp_err[n] !== mE.err ||
            (mE.vld && mData !== mE.data)) begin
          nFail++;
          $display("FAIL rsp core%0d cyc %0d: got vld=%b err=%b data=%h, expected vld=%b err=%b data=%h",
                   n, cyc, rsp_valid[n], rsp_err[n], mData, mE.vld, mE.err, mE.data);
        end
      end else if (rsp_valid[n] || rsp_err[n]) begin
        nChecks++;
        nFail++;
        $display("FAIL rsp core%0d cyc %0d: unexpected vld=%b err=%b, expected none",
                 n, cyc, rsp_valid[n], rsp_err[n]);
      end
    end
  end

  // One request cycle. Called #1 after a rising edge; returns #1 after the
  // accepting edge. Checks req_ready against the bench's own arbiter model.
  task automatic step(input logic [1:0] v, input logic [1:0] w,
                      input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1);
    logic        conf;
    logic [1:0]  expRdy, acc;
    logic [15:0] a, d;
    exp_t        e;
    req_valid = v; req_write = w;
    req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
    @(negedge clk);
    conf   = v[0] && v[1] && (a0[7:0] == a1[7:0]) && (w[0] || w[1]);
    expRdy = conf ? (rrModel ? 2'b10 : 2'b01) : 2'b11;
    nChecks++;
    if (req_ready !== expRdy) begin
      nFail++;
      if (nFail < 20)
        $display("FAIL req_ready cyc %0d: got %b, expected %b", cyc, req_ready, expRdy);
    end
    acc = v & expRdy;
    for (int n = 0; n < 2; n++) if (acc[n]) begin
      a = (n == 0) ? a0 : a1;
      d = (n == 0) ? d0 : d1;
      e.err = (a[15:8] != 8'h00);
      e.vld = !w[n];
      e.data = e.err ? 16'h0 : refMem[a[7:0]];
      e.due = cyc + 3;
      if (e.vld || e.err) begin
        if (n == 0) sb0.push_back(e);
        else        sb1.push_back(e);
      end
      if (w[n] && !e.err) refMem[a[7:0]] = d;
    end
    if (conf) begin
      rrModel = ~rrModel;
      if (cntModel != 16'hFFFF) cntModel = cntModel + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic drain;
    idle(4);
    nChecks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      nFail++;
      $display("FAIL drain: pending responses core0=%0d core1=%0d, expected 0", sb0.size(), sb1.size());
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #3;
    nChecks++;
    if ({dataWrite, dataLoad, dataADDR0, dataADDR1, dataIN0, dataIN1,
         rsp_valid, rsp_err, rsp_data0, rsp_data1} !== '0) begin
      nFail++;
      $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    nChecks++;
    if (conflict_cnt !== 16'h0) begin
      nFail++;
      $display("FAIL reset_cnt: got %h, expected 0000", conflict_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_parallel;
    step(2'b11, 2'b11, 16'h0010, 16'h0020, 16'h1234, 16'hBEEF);
    step(2'b11, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0);
    drain();
  endtask

  task automatic test_conflict;
    logic [15:0] c0;
    c0 = cntModel;
    step(2'b11, 2'b11, 16'h0005, 16'h0005, 16'h1111, 16'h2222);
    step(2'b11, 2'b11, 16'h0005, 16'h0005, 16'h1111, 16'h2222);
    step(2'b01, 2'b00, 16'h0005, 16'h0000, 16'h0, 16'h0);
    drain();
    nChecks++;
    if (conflict_cnt !== c0 + 16'd2) begin
      nFail++;
      $display("FAIL conflict_cnt: got %h, expected %h", conflict_cnt, c0 + 16'd2);
    end
  endtask

  task automatic test_load_load;
    logic [15:0] c0;
    c0 = conflict_cnt;
    step(2'b11, 2'b00, 16'h0005, 16'h0005, 16'h0, 16'h0);
    drain();
    nChecks++;
    if (conflict_cnt !== c0) begin
      nFail++;
      $display("FAIL load_load_cnt: got %h, expected %h", conflict_cnt, c0);
    end
  endtask

  task automatic test_out_of_range;
    step(2'b10, 2'b00, 16'h0000, 16'h0100, 16'h0, 16'h0);
    nChecks++;
    if (dataLoad[1] !== 1'b0 || dataADDR1 !== 16'h0100) begin
      nFail++;
      $display("FAIL oor_issue: got dataLoad1=%b addr1=%h, expected 0 / 0100", dataLoad[1], dataADDR1);
    end
    step(2'b01, 2'b01, 16'h0000, 16'h0000, 16'h7777, 16'h0);
    step(2'b10, 2'b10, 16'h0000, 16'h0100, 16'h0, 16'hDEAD);
    nChecks++;
    if (dataWrite[1] !== 1'b0) begin
      nFail++;
      $display("FAIL oor_store: got dataWrite1=%b, expected 0", dataWrite[1]);
    end
    idle(1);
    step(2'b01, 2'b00, 16'h0000, 16'h0000, 16'h0, 16'h0);
    drain();
  endtask

  task automatic test_back_to_back;
    step(2'b11, 2'b01, 16'h0030, 16'h0010, 16'hA5A5, 16'h0);
    step(2'b11, 2'b00, 16'h0030, 16'h0020, 16'h0, 16'h0);
    step(2'b11, 2'b10, 16'h0030, 16'h0040, 16'h0, 16'h5A5A);
    step(2'b10, 2'b00, 16'h0000, 16'h0040, 16'h0, 16'h0);
    drain();
  endtask

  task automatic test_reset_midop;
    step(2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0, 16'h0);
    #2;
    rst = 1'b0;
    sb0.delete(); sb1.delete();
    rrModel = 1'b0; cntModel = '0;
    #1;
    nChecks++;
    if ({dataLoad, dataADDR0, rsp_valid, rsp_data0, conflict_cnt} !== '0) begin
      nFail++;
      $display("FAIL midop_reset: got nonzero outputs (cnt=%h), expected all 0", conflict_cnt);
    end
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    rspSeen = 0;
    step(2'b11, 2'b11, 16'h0005, 16'h0005, 16'hAAAA, 16'hBBBB);
    idle(4);
    nChecks++;
    if (rspSeen != 0) begin
      nFail++;
      $display("FAIL midop_no_rsp: got %0d rsp_valid pulses, expected 0", rspSeen);
    end
    step(2'b01, 2'b00, 16'h0005, 16'h0000, 16'h0, 16'h0);
    drain();
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 65600; i++)
      step(2'b11, 2'b11, 16'h0005, 16'h0005, 16'h1111, 16'h2222);
    idle(1);
    nChecks++;
    if (conflict_cnt !== 16'hFFFF) begin
      nFail++;
      $display("FAIL saturation: got %h, expected FFFF", conflict_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_conflict();
    test_load_load();
    test_out_of_range();
    test_back_to_back();
    test_reset_midop();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
